// File: rtl/debug_pkg.sv
// ----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug-slave Avalon master: the FSM state type,
// the debug register window indices and the control-register bit positions
// that the host bridge uses to halt, step and inspect the core.
// ----------------------------------------------------------------------------
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Debug slave register window (word addresses)
  localparam logic [2:0] DBG_CTRL  = 3'd0;
  localparam logic [2:0] DBG_IADDR = 3'd1;
  localparam logic [2:0] DBG_EADDR = 3'd2;
  localparam logic [2:0] DBG_DATA  = 3'd3;

  // Bit positions inside DBG_CTRL
  localparam int unsigned CTRL_NDEBUG  = 0;
  localparam int unsigned CTRL_RUN     = 1;
  localparam int unsigned CTRL_SEL_LSB = 3;

endpackage

// File: rtl/debug_timeout_counter.sv
// ----------------------------------------------------------------------------
// debug_timeout_counter
// Counts consecutive stall cycles of one bus access and flags the cycle in
// which the LIMIT-th stall is being counted, so the master can abort at the
// same edge. The count saturates at LIMIT.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    restart the count (start of a new access)
//   inc_i      this cycle is a stall cycle
//   expired_o  high while counting the LIMIT-th consecutive stall
// ----------------------------------------------------------------------------
module debug_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Look-ahead: the stall being counted now is the LIMIT-th one.
  assign expired_o = inc_i && (count_q >= LAST);

endmodule

// File: rtl/avalon_debug_master.sv
// ----------------------------------------------------------------------------
// avalon_debug_master
// Avalon-MM master for the debug slave register window. Accepts one host
// command at a time, runs a single read or write on the bus honouring
// waitrequest, and returns read data or a timeout error. All outputs are
// registered.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload (1 = write)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/rsp_error      read data (0 for writes/errors), timeout flag
//   chipselect, address, write, writedata, read, readdata, waitrequest
//                            Avalon-MM master side
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// ACCESS | strobes on the bus, waiting for waitrequest low or timeout
// RDWAIT | read accepted, counting fixed read latency, bus idle
// RESP   | response held until rsp_ready
// ----------------------------------------------------------------------------
module avalon_debug_master
  import debug_pkg::*;
#(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              chipselect,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              chipselect_q, chipselect_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic [1:0]        lat_q, lat_d;

  logic tmo_clear, tmo_inc, tmo_expired;

  debug_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .clear_i   (tmo_clear),
    .inc_i     (tmo_inc),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    chipselect_d = chipselect_q;
    write_d      = write_q;
    read_d       = read_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    lat_d        = lat_q;
    tmo_clear    = 1'b0;
    tmo_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          // Strobes are loaded here so they appear in the first ACCESS cycle.
          cmd_ready_d  = 1'b0;
          chipselect_d = 1'b1;
          write_d      = cmd_write;
          read_d       = !cmd_write;
          address_d    = cmd_addr;
          writedata_d  = cmd_wdata;
          tmo_clear    = 1'b1;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        if (!waitrequest) begin
          // Acceptance takes priority over a timeout expiring this cycle.
          chipselect_d = 1'b0;
          write_d      = 1'b0;
          read_d       = 1'b0;
          if (write_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b0;
            state_d     = RESP;
          end else if (READ_LATENCY == 0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = readdata;
            rsp_error_d = 1'b0;
            state_d     = RESP;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = RDWAIT;
          end
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expired) begin
            chipselect_d = 1'b0;
            write_d      = 1'b0;
            read_d       = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_error_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end

      RDWAIT: begin
        if (lat_q == 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = readdata;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      chipselect_q <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      lat_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      chipselect_q <= chipselect_d;
      write_q      <= write_d;
      read_q       <= read_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
      lat_q        <= lat_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign chipselect = chipselect_q;
  assign write      = write_q;
  assign read       = read_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;

endmodule
